// File: rtl/dm_axi_pkg.sv
// rtl/dm_axi_pkg.sv - shared types, AXI single-beat defaults and lane-shift helper for dm_axi_master
package dm_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } dm_state_e;

  // Fixed channel attributes the wrapper ties off: one beat, 32-bit, INCR.
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [2:0] AXI_SIZE  = 3'b010;
  localparam logic [1:0] AXI_BURST = 2'b01;

  function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

endpackage

// File: rtl/dm_axi_master_if.sv
// rtl/dm_axi_master_if.sv - single-beat AXI data-memory bus with master/slave views
interface dm_axi_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, arready, rdata, rvalid
  );
endinterface

// File: rtl/dm_axi_master.sv
// rtl/dm_axi_master.sv - CPU MEM-stage to single-beat AXI master bridge; DM_POSTED_WRITE_EN enables posted stores
module dm_axi_master
  import dm_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_on,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_wstrb,
  input  logic              cpu_hold,
  output logic [31:0]       dm_rdata,
  output logic              dm_stall,
  dm_axi_master_if.master   axi
);

  dm_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        strb_q;
  logic              aw_done, w_done;
  logic              awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic              aw_hs, w_hs, aw_fin, w_fin, accept;

  assign aw_hs  = awvalid_q && axi.awready;
  assign w_hs   = wvalid_q && axi.wready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

`ifdef DM_POSTED_WRITE_EN
  logic b_pending;
  // A posted store's B must drain before any new request is launched.
  assign accept = dm_on && !b_pending;
`else
  assign accept = dm_on;
`endif

  assign dm_stall    = dm_on && (state != DONE);
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = data_q;
  assign axi.wstrb   = strb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      dm_rdata  <= '0;
`ifdef DM_POSTED_WRITE_EN
      b_pending <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= {dm_addr[ADDR_W-1:2], 2'b00};
            strb_q  <= dm_wstrb;
            data_q  <= lane_shift(dm_wdata, dm_addr[1:0]);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (dm_wstrb != 4'b0000) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            dm_rdata <= axi.rdata;
            rready_q <= 1'b0;
            state    <= DONE;
          end
        end
        WR_REQ: begin
          // AW and W retire independently so neither beat is ever repeated.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_fin && w_fin) begin
`ifdef DM_POSTED_WRITE_EN
            state <= DONE;
`else
            bready_q <= 1'b1;
            state    <= WR_RESP;
`endif
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!cpu_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

`ifdef DM_POSTED_WRITE_EN
      if (state == WR_REQ && aw_fin && w_fin) begin
        b_pending <= 1'b1;
        bready_q  <= 1'b1;
      end else if (bready_q && axi.bvalid) begin
        b_pending <= 1'b0;
        bready_q  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dm_axi_master.sv
// tb/tb_dm_axi_master.sv - scoreboard bench for dm_axi_master; DM_POSTED_WRITE_EN selects posted-store expectations
module tb_dm_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_on;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        cpu_hold;
  logic [31:0] dm_rdata;
  logic        dm_stall;

  dm_axi_master_if #(.ADDR_W(32)) axi ();

  dm_axi_master #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .dm_on    (dm_on),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wstrb (dm_wstrb),
    .cpu_hold (cpu_hold),
    .dm_rdata (dm_rdata),
    .dm_stall (dm_stall),
    .axi      (axi)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_r[$];

  int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  int ar_n = 0, aw_n = 0, w_n = 0, r_n = 0, b_n = 0;
  int awv_cyc = 0, wv_cyc = 0;
  int r_ow, b_ow;
  logic [31:0] rdata_val = '0;
  logic        r_chk = 1'b0;
  logic [31:0] r_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model drives on the falling edge; handshakes are scored 1ns later,
  // i.e. exactly the beats the DUT will see on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (r_chk) begin
        check("dm_rdata", 64'(dm_rdata), 64'(r_exp));
        r_chk = 1'b0;
      end
      if (rst) begin
        axi.arready = 0; axi.awready = 0; axi.wready = 0; axi.rvalid = 0; axi.bvalid = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        r_n = ar_n;
        b_n = (aw_n < w_n) ? aw_n : w_n;
      end else begin
        axi.arready = axi.arvalid && (ar_cnt >= ar_dly);
        ar_cnt      = axi.arvalid ? ar_cnt + 1 : 0;
        axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
        aw_cnt      = axi.awvalid ? aw_cnt + 1 : 0;
        axi.wready  = axi.wvalid && (w_cnt >= w_dly);
        w_cnt       = axi.wvalid ? w_cnt + 1 : 0;
        r_ow        = ar_n - r_n;
        axi.rvalid  = (r_ow > 0) && (r_cnt >= r_dly);
        r_cnt       = (r_ow > 0) ? r_cnt + 1 : 0;
        axi.rdata   = rdata_val;
        b_ow        = ((aw_n < w_n) ? aw_n : w_n) - b_n;
        axi.bvalid  = (b_ow > 0) && (b_cnt >= b_dly);
        b_cnt       = (b_ow > 0) ? b_cnt + 1 : 0;
      end
      #1;
      if (!rst) begin
        if (axi.awvalid) awv_cyc++;
        if (axi.wvalid) wv_cyc++;
        if (axi.arvalid && axi.arready) begin
          ar_n++;
          check("ar_expected", 64'(exp_ar.size() > 0), 64'(1));
          if (exp_ar.size() > 0) check("araddr", 64'(axi.araddr), 64'(exp_ar.pop_front()));
        end
        if (axi.awvalid && axi.awready) begin
          aw_n++;
          check("aw_expected", 64'(exp_aw.size() > 0), 64'(1));
          if (exp_aw.size() > 0) check("awaddr", 64'(axi.awaddr), 64'(exp_aw.pop_front()));
        end
        if (axi.wvalid && axi.wready) begin
          w_n++;
          check("w_expected", 64'(exp_w.size() > 0), 64'(1));
          if (exp_w.size() > 0) check("wdata_wstrb", 64'({axi.wdata, axi.wstrb}), 64'(exp_w.pop_front()));
        end
        if (axi.rvalid && axi.rready) begin
          r_n++;
          check("r_expected", 64'(exp_r.size() > 0), 64'(1));
          if (exp_r.size() > 0) begin
            r_exp = exp_r.pop_front();
            r_chk = 1'b1;
          end
        end
        if (axi.bvalid && axi.bready) b_n++;
      end
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                        input int hold, input int exp_stall, input string name);
    int stall_n = 0;
    dm_on = 1'b1; dm_addr = addr; dm_wdata = wd; dm_wstrb = st;
    #1;
    while (dm_stall && stall_n < 100) begin
      stall_n++;
      @(negedge clk);
      #1;
    end
    check({name, "_stall"}, 64'(stall_n), 64'(exp_stall));
    cpu_hold = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check({name, "_hold_stall"}, 64'(dm_stall), 64'(0));
      check({name, "_hold_no_reissue"}, 64'(axi.arvalid | axi.awvalid), 64'(0));
    end
    cpu_hold = 1'b0;
    @(negedge clk);
    dm_on = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] rd, input logic [31:0] ex_ar,
                         input int hold, input int exp_stall, input string name);
    rdata_val = rd;
    exp_ar.push_back(ex_ar);
    exp_r.push_back(rd);
    do_req(addr, 32'h0, 4'b0000, hold, exp_stall, name);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                          input logic [31:0] ex_aw, input logic [35:0] ex_w,
                          input int exp_stall, input string name);
    exp_aw.push_back(ex_aw);
    exp_w.push_back(ex_w);
    do_req(addr, wd, st, 0, exp_stall, name);
  endtask

  int aw0, w0, ar0, awv0, wv0, b0;

  initial begin
    rst = 1'b1; dm_on = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; cpu_hold = 1'b0;
    axi.arready = 0; axi.awready = 0; axi.wready = 0; axi.rvalid = 0; axi.bvalid = 0; axi.rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dm_rdata", 64'(dm_rdata), 64'(0));
    check("rst_dm_stall", 64'(dm_stall), 64'(0));
    check("rst_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    do_load(32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_1004, 0, 3, "lw_1004");

    aw0 = aw_n; w0 = w_n;
    do_store(32'h0000_2003, 32'h0000_00AB, 4'b1000, 32'h0000_2000, {32'hAB00_0000, 4'b1000}, 3, "sb_2003");
    check("sb_aw_count", 64'(aw_n - aw0), 64'(1));
    check("sb_w_count", 64'(w_n - w0), 64'(1));
    check("rdata_held_after_store", 64'(dm_rdata), 64'(32'hDEAD_BEEF));

    aw_dly = 4;
    aw0 = aw_n; w0 = w_n; awv0 = awv_cyc; wv0 = wv_cyc;
    do_store(32'h0000_3008, 32'h1234_5678, 4'b1111, 32'h0000_3008, {32'h1234_5678, 4'b1111}, 7, "sw_aw_late");
    check("late_wvalid_cycles", 64'(wv_cyc - wv0), 64'(1));
    check("late_awvalid_cycles", 64'(awv_cyc - awv0), 64'(5));
    check("late_aw_count", 64'(aw_n - aw0), 64'(1));
    check("late_w_count", 64'(w_n - w0), 64'(1));
    aw_dly = 0;

    do_store(32'h0000_4002, 32'h0000_BEEF, 4'b1100, 32'h0000_4000, {32'hBEEF_0000, 4'b1100}, 3, "sh_4002");

    ar0 = ar_n;
    do_load(32'h0000_5000, 32'hCAFE_F00D, 32'h0000_5000, 3, 3, "lw_hold");
    check("hold_ar_count", 64'(ar_n - ar0), 64'(1));

    // Reset while the read is parked in RD_DATA waiting on a slow slave.
    r_dly = 10;
    rdata_val = 32'h5555_AAAA;
    exp_ar.push_back(32'h0000_6000);
    dm_on = 1'b1; dm_addr = 32'h0000_6000; dm_wstrb = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_rready", 64'(axi.rready), 64'(1));
    #1;
    rst = 1'b1; dm_on = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready}), 64'(0));
    check("midrst_dm_rdata", 64'(dm_rdata), 64'(0));
    check("midrst_dm_stall", 64'(dm_stall), 64'(0));
    #1;
    rst = 1'b0; r_dly = 0;
    @(negedge clk);
    do_load(32'h0000_6004, 32'h0BAD_C0DE, 32'h0000_6004, 0, 3, "lw_after_rst");

    b_dly = 5;
    b0 = b_n;
`ifdef DM_POSTED_WRITE_EN
    do_store(32'h0000_7000, 32'hA5A5_A5A5, 4'b1111, 32'h0000_7000, {32'hA5A5_A5A5, 4'b1111}, 2, "sw_posted");
    check("posted_b_outstanding", 64'(b_n - b0), 64'(0));
    do_load(32'h0000_7004, 32'h1122_3344, 32'h0000_7004, 0, 8, "lw_behind_b");
`else
    do_store(32'h0000_7000, 32'hA5A5_A5A5, 4'b1111, 32'h0000_7000, {32'hA5A5_A5A5, 4'b1111}, 8, "sw_slow_b");
    check("slow_b_done", 64'(b_n - b0), 64'(1));
    do_load(32'h0000_7004, 32'h1122_3344, 32'h0000_7004, 0, 3, "lw_after_b");
`endif
    check("b_count_final", 64'(b_n - b0), 64'(1));
    b_dly = 0;

    @(negedge clk);
    check("exp_ar_left", 64'(exp_ar.size()), 64'(0));
    check("exp_aw_left", 64'(exp_aw.size()), 64'(0));
    check("exp_w_left", 64'(exp_w.size()), 64'(0));
    check("exp_r_left", 64'(exp_r.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
